// File: rtl/mpy_share_ctrl_pkg.sv
// Shared constants and types for the multiplier-sharing issue controller.
package mpy_pkg;

    localparam int unsigned OPW   = 8;
    localparam int unsigned PRODW = 16;
    localparam int unsigned IDW   = 2;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } mpy_tag_t;

    // Requester id to one-hot, sized for the largest supported requester count.
    function automatic logic [3:0] id_onehot(input logic [IDW-1:0] id);
        id_onehot = 4'b0001 << id;
    endfunction

endpackage

// File: rtl/mpy_share_ctrl_if.sv
// Requester-side handshake and multiplier datapath signals of the shared multiplier.
interface mpy_share_ctrl_if #(
    parameter int unsigned NREQ = 2
);
    import mpy_pkg::*;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [OPW*NREQ-1:0]       req_a;
    logic [OPW*NREQ-1:0]       req_b;
    logic [NREQ-1:0]           rsp_valid;
    logic signed [PRODW-1:0]   rsp_product;
    logic signed [OPW-1:0]     mpy_a;
    logic signed [OPW-1:0]     mpy_b;
    logic signed [PRODW-1:0]   mpy_product;

    // Requesters plus multiplier model on one side.
    modport master (
        output req_valid, req_a, req_b, mpy_product,
        input  req_ready, rsp_valid, rsp_product, mpy_a, mpy_b
    );

    // Issue controller side.
    modport slave (
        input  req_valid, req_a, req_b, mpy_product,
        output req_ready, rsp_valid, rsp_product, mpy_a, mpy_b
    );

endinterface

// File: rtl/mpy_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first valid request at or after ptr, modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] ptr_nxt
);

    localparam int unsigned PW = $clog2(NREQ);

    logic found;

    // Search offset k from ptr; requester j sits at offset k when (ptr + k) mod NREQ == j.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            for (int j = 0; j < int'(NREQ); j++) begin
                if (en && !found && req[j] &&
                    ((int'(ptr) + k == j) || (int'(ptr) + k == j + int'(NREQ)))) begin
                    gnt[j]  = 1'b1;
                    found   = 1'b1;
                    ptr_nxt = (j == int'(NREQ) - 1) ? '0 : PW'(j + 1);
                end
            end
        end
    end

endmodule

// File: rtl/mpy_share_ctrl.sv
// Issue controller sharing one pipelined signed 8x8 multiplier among NREQ requesters;
// a LAT-deep tag line steers each product back to the requester that issued it.
module mpy_share_ctrl
    import mpy_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned LAT  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    mpy_share_ctrl_if.slave            bus,
    output logic [$clog2(LAT+1)-1:0]   inflight,
    output logic                       busy
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(LAT + 1);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt_c;
    logic [NREQ-1:0] gnt_c;
    logic            grant_c;
    logic [IDW-1:0]  gnt_id_c;
    logic [OPW-1:0]  sel_a_c;
    logic [OPW-1:0]  sel_b_c;
    logic            rsp_fire_c;
    logic [CW-1:0]   inflight_nxt_c;
    mpy_tag_t        tag_q [LAT];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .en      (!hold),
        .ptr     (ptr),
        .gnt     (gnt_c),
        .ptr_nxt (ptr_nxt_c)
    );

    assign bus.req_ready = gnt_c;
    assign grant_c       = |gnt_c;
    assign rsp_fire_c    = tag_q[LAT-1].valid;

    // Encode the one-hot grant and select the granted requester's operands.
    always_comb begin
        gnt_id_c = '0;
        sel_a_c  = '0;
        sel_b_c  = '0;
        for (int j = 0; j < int'(NREQ); j++) begin
            if (gnt_c[j]) begin
                gnt_id_c = IDW'(j);
                sel_a_c  = bus.req_a[OPW*j +: OPW];
                sel_b_c  = bus.req_b[OPW*j +: OPW];
            end
        end
    end

    always_comb begin
        inflight_nxt_c = inflight;
        if (grant_c && !rsp_fire_c) begin
            inflight_nxt_c = inflight + CW'(1);
        end else if (!grant_c && rsp_fire_c) begin
            inflight_nxt_c = inflight - CW'(1);
        end
    end

    // Operands only load on a grant so the multiplier inputs stay quiet when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            bus.mpy_a <= '0;
            bus.mpy_b <= '0;
        end else begin
            ptr <= ptr_nxt_c;
            if (grant_c) begin
                bus.mpy_a <= sel_a_c;
                bus.mpy_b <= sel_b_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(LAT); s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= mpy_tag_t'{valid: grant_c, id: gnt_id_c};
            for (int s = 1; s < int'(LAT); s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid   <= '0;
            bus.rsp_product <= '0;
        end else begin
            bus.rsp_valid <= rsp_fire_c ? NREQ'(id_onehot(tag_q[LAT-1].id)) : '0;
            if (rsp_fire_c) begin
                bus.rsp_product <= bus.mpy_product;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            busy     <= 1'b0;
        end else begin
            inflight <= inflight_nxt_c;
            busy     <= (inflight_nxt_c != '0);
        end
    end

endmodule
